// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side helper blocks: reader state encoding,
// default beat geometry and the counter width helper.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } deq_state_t;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_NBEATS = 4;

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_deq_serializer.sv
// Reader end of a FIFO: dequeues one wide word and emits it as nbeats narrow
// beats, least-significant lane first, with a valid/ready handshake downstream.
module fifo_deq_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned width  = DEFAULT_WIDTH,
    parameter int unsigned nbeats = DEFAULT_NBEATS
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CLR,
    input  logic [width*nbeats-1:0]  IN_D,
    input  logic                     IN_EMPTY_N,
    output logic                     IN_DEQ,
    output logic [width-1:0]         OUT_D,
    output logic                     OUT_VALID,
    input  logic                     OUT_RDY,
    output logic                     OUT_LAST
);

    localparam int unsigned cnt_w = cnt_width(nbeats);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(nbeats - 1);

    deq_state_t               state;
    deq_state_t               next_state;
    logic [cnt_w-1:0]         cnt;
    logic [width*nbeats-1:0]  shreg;
    logic                     beat_fire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) state <= IDLE;
        else               state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a latch behind.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (IN_DEQ) next_state = BUSY;
            BUSY: if (OUT_RDY && OUT_LAST) next_state = IN_DEQ ? BUSY : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are gated by RST_N so they read inactive during reset even
    // before the first edge has settled the state register.
    always_comb begin
        OUT_VALID = 1'b0;
        OUT_LAST  = 1'b0;
        IN_DEQ    = 1'b0;
        if (RST_N) begin
            OUT_VALID = (state == BUSY);
            OUT_LAST  = (state == BUSY) && (cnt == last_cnt);
            IN_DEQ    = IN_EMPTY_N && !CLR &&
                        ((state == IDLE) || ((state == BUSY) && OUT_RDY && OUT_LAST));
        end
    end

    assign beat_fire = OUT_VALID && OUT_RDY;
    assign OUT_D     = shreg[width-1:0];

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR)  cnt <= '0;
        else if (IN_DEQ)    cnt <= '0;
        else if (beat_fire) cnt <= cnt + cnt_w'(1);
    end

    // NOTE: the shift register is deliberately left out of reset; its contents
    // are only observed while OUT_VALID is high, which requires a fresh load.
    always_ff @(posedge CLK) begin
        if (IN_DEQ)         shreg <= IN_D;
        else if (beat_fire) shreg <= {width'(0), shreg[width*nbeats-1:width]};
    end

    // Flags a dequeue strobe issued against an empty upstream FIFO.
    deq_on_empty: assert property (@(posedge CLK) disable iff (!RST_N) !(IN_DEQ && !IN_EMPTY_N))
        else $warning("fifo_deq_serializer: IN_DEQ asserted while IN_EMPTY_N=0");

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Directed bench for fifo_deq_serializer (width=8, nbeats=4) with a small
// queue standing in for the upstream 2-deep FIFO.
module tb_fifo_deq_serializer;

    localparam int unsigned width  = 8;
    localparam int unsigned nbeats = 4;

    logic                    CLK = 1'b0;
    logic                    RST_N = 1'b0;
    logic                    CLR = 1'b0;
    logic [width*nbeats-1:0] IN_D = '0;
    logic                    IN_EMPTY_N = 1'b0;
    logic                    IN_DEQ;
    logic [width-1:0]        OUT_D;
    logic                    OUT_VALID;
    logic                    OUT_RDY = 1'b1;
    logic                    OUT_LAST;

    logic [31:0] q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          deq_count = 0;

    fifo_deq_serializer #(.width(width), .nbeats(nbeats)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CLR        (CLR),
        .IN_D       (IN_D),
        .IN_EMPTY_N (IN_EMPTY_N),
        .IN_DEQ     (IN_DEQ),
        .OUT_D      (OUT_D),
        .OUT_VALID  (OUT_VALID),
        .OUT_RDY    (OUT_RDY),
        .OUT_LAST   (OUT_LAST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        IN_EMPTY_N = (q.size() != 0);
        IN_D       = (q.size() != 0) ? q[0] : '0;
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        refresh();
    endtask

    // Advance one clock; the upstream model pops exactly when a dequeue
    // handshake was presented at the edge.
    task automatic tick();
        bit deq_now;
        deq_now = IN_DEQ && IN_EMPTY_N;
        @(posedge CLK);
        #1;
        if (deq_now) begin
            void'(q.pop_front());
            deq_count++;
        end
        refresh();
    endtask

    logic [7:0] seq_a[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] seq_b[8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] seq_c[4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic       rdy_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int d0;
        int idx;

        // Reset held for three edges with a word waiting upstream.
        push(32'h44332211);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_deq_c%0d", c), IN_DEQ, 0);
            check($sformatf("rst_valid_c%0d", c), OUT_VALID, 0);
            check($sformatf("rst_last_c%0d", c), OUT_LAST, 0);
            tick();
        end
        RST_N = 1'b1;
        #1;
        check("post_rst_deq", IN_DEQ, 1);
        check("post_rst_valid", OUT_VALID, 0);

        // Single word, downstream always ready: first beat one cycle later.
        d0 = deq_count;
        tick();
        for (int b = 0; b < 4; b++) begin
            check($sformatf("single_valid_b%0d", b), OUT_VALID, 1);
            check($sformatf("single_d_b%0d", b), OUT_D, seq_a[b]);
            check($sformatf("single_last_b%0d", b), OUT_LAST, (b == 3));
            check($sformatf("single_deq_b%0d", b), IN_DEQ, 0);
            tick();
        end
        check("single_idle_valid", OUT_VALID, 0);
        check("single_deq_pulses", deq_count - d0, 1);

        // Back-to-back words: eight beats without a bubble.
        push(32'h44332211);
        push(32'h88776655);
        check("b2b_c0_valid", OUT_VALID, 0);
        for (int c = 0; c < 9; c++) begin
            check($sformatf("b2b_deq_c%0d", c), IN_DEQ, (c == 0 || c == 4));
            if (c >= 1) begin
                check($sformatf("b2b_valid_c%0d", c), OUT_VALID, 1);
                check($sformatf("b2b_d_c%0d", c), OUT_D, seq_b[c-1]);
                check($sformatf("b2b_last_c%0d", c), OUT_LAST, (c == 4 || c == 8));
            end
            tick();
        end
        check("b2b_idle_valid", OUT_VALID, 0);

        // Backpressure: data must hold across stalls, no loss or duplication.
        push(32'h44332211);
        tick();
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            OUT_RDY = rdy_pat[i];
            #1;
            check($sformatf("bp_valid_i%0d", i), OUT_VALID, 1);
            check($sformatf("bp_d_i%0d", i), OUT_D, seq_a[idx]);
            check($sformatf("bp_last_i%0d", i), OUT_LAST, (idx == 3));
            if (rdy_pat[i]) idx++;
            tick();
        end
        OUT_RDY = 1'b1;
        #1;
        check("bp_beats_done", idx, 4);
        check("bp_idle_valid", OUT_VALID, 0);

        // Clear after two beats, with the next word already waiting.
        push(32'h44332211);
        push(32'hDDCCBBAA);
        tick();
        check("clr_d0", OUT_D, 8'h11);
        tick();
        check("clr_d1", OUT_D, 8'h22);
        tick();
        CLR = 1'b1;
        #1;
        check("clr_cycle_deq", IN_DEQ, 0);
        tick();
        CLR = 1'b0;
        #1;
        check("clr_after_valid", OUT_VALID, 0);
        check("clr_after_deq", IN_DEQ, 1);
        tick();
        for (int b = 0; b < 4; b++) begin
            check($sformatf("clr_next_d_b%0d", b), OUT_D, seq_c[b]);
            check($sformatf("clr_next_last_b%0d", b), OUT_LAST, (b == 3));
            tick();
        end
        check("clr_next_idle", OUT_VALID, 0);

        // Reset after one beat: partial word dropped, no dequeue while in reset.
        push(32'h44332211);
        tick();
        check("rmid_d0", OUT_D, 8'h11);
        tick();
        push(32'hDDCCBBAA);
        RST_N = 1'b0;
        #1;
        d0 = deq_count;
        check("rmid_deq_a", IN_DEQ, 0);
        check("rmid_valid_a", OUT_VALID, 0);
        tick();
        check("rmid_deq_b", IN_DEQ, 0);
        check("rmid_valid_b", OUT_VALID, 0);
        tick();
        check("rmid_no_deq", deq_count - d0, 0);
        RST_N = 1'b1;
        #1;
        check("rmid_rel_deq", IN_DEQ, 1);
        check("rmid_rel_valid", OUT_VALID, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            check($sformatf("rmid_next_d_b%0d", b), OUT_D, seq_c[b]);
            check($sformatf("rmid_next_last_b%0d", b), OUT_LAST, (b == 3));
            tick();
        end
        check("rmid_idle", OUT_VALID, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_deq_serializer.md
FIFO_DEQ_SERIALIZER -- requirements
Module: fifo_deq_serializer

Interface
REQ-001 Parameter: width, default 8, bits per output beat.
REQ-002 Parameter: nbeats, default 4, beats per input word; power of 2, at least 2.
REQ-003 Ports: CLK  input  1  clock; all state updates on the rising edge.
REQ-004 Ports: RST_N  input  1  reset, synchronous, active-low.
REQ-005 Ports: CLR  input  1  synchronous clear; discards any word in progress.
REQ-006 Ports: IN_D  input  width*nbeats  upstream FIFO data (D_OUT side).
REQ-007 Ports: IN_EMPTY_N  input  1  upstream FIFO holds a word.
REQ-008 Ports: IN_DEQ  output  1  dequeue strobe to the upstream FIFO.
REQ-009 Ports: OUT_D  output  width  current beat.
REQ-010 Ports: OUT_VALID  output  1  OUT_D is valid.
REQ-011 Ports: OUT_RDY  input  1  downstream accepts the beat this cycle.
REQ-012 Ports: OUT_LAST  output  1  current beat is the final beat of its word.

Function
REQ-013 Block SHALL act as the reader end of the team's FIFO handshake: a word is consumed only in a cycle where IN_DEQ=1 and IN_EMPTY_N=1.
REQ-014 State machine SHALL have two states: IDLE (no word held) and BUSY (word held, beats pending).
REQ-015 IN_DEQ SHALL be combinational and equal to: IN_EMPTY_N & !CLR & (IDLE | (BUSY & OUT_RDY & OUT_LAST)).
REQ-016 IN_DEQ SHALL never be asserted while IN_EMPTY_N=0.
REQ-017 On IN_DEQ, IN_D SHALL be captured into a shift register, the beat counter SHALL be set to 0, and the state SHALL become BUSY.
REQ-018 OUT_VALID SHALL be 1 exactly in BUSY.
REQ-019 OUT_D SHALL equal lane 0 (bits width-1:0) of the shift register.
REQ-020 Beat order SHALL be least-significant lane first.
REQ-021 On OUT_VALID & OUT_RDY, the register SHALL shift right by width bits and the counter SHALL increment modulo nbeats.
REQ-022 OUT_LAST SHALL be 1 when BUSY and counter = nbeats-1.
REQ-023 On the last beat accepted with IN_DEQ=1, the next word SHALL reload in the same cycle with no bubble.
REQ-024 On the last beat accepted with IN_DEQ=0, the state SHALL return to IDLE.
REQ-025 Latency: a word present at cycle N with the block in IDLE SHALL give its first beat on OUT_D at cycle N+1.
REQ-026 Sustained throughput SHALL be one beat per cycle while IN_EMPTY_N=1 and OUT_RDY=1.
REQ-027 While OUT_VALID=1 and OUT_RDY=0, OUT_D, OUT_LAST and the counter SHALL hold stable.
REQ-028 CLR=1 SHALL force IDLE and counter 0 at the next edge, and SHALL suppress IN_DEQ in that cycle; CLR has priority over all other events.
REQ-029 Simulation-only check: SHALL print a warning if the IN_DEQ=1 and IN_EMPTY_N=0 condition is ever seen.

Reset
REQ-030 While RST_N=0 at an edge, the block SHALL enter IDLE with counter 0.
REQ-031 During reset: OUT_VALID=0, OUT_LAST=0, IN_DEQ=0.
REQ-032 The shift register SHALL NOT be reset; OUT_D is don't-care while OUT_VALID=0.
REQ-033 Reset mid-word SHALL discard the partial word without issuing a dequeue.

Structure
REQ-034 Shared package fifo_pkg SHALL hold the IDLE/BUSY state encoding and the default width and nbeats constants.
REQ-035 The counter width SHALL be clog2(nbeats), defined in fifo_pkg as a function.
REQ-036 No sub-module; a single module with one state register, one counter and one shift register.

Verification (width=8, nbeats=4; upstream is the team's 2-deep FIFO primitive)
REQ-037 Reset: RST_N=0 for 3 cycles with IN_EMPTY_N=1 -> IN_DEQ=0 and OUT_VALID=0 throughout; IN_DEQ=1 in the first cycle after release.
REQ-038 Single word: 0x44332211 with OUT_RDY=1 -> OUT_D = 11, 22, 33, 44 on 4 consecutive cycles; OUT_LAST set only with 44; exactly one IN_DEQ pulse.
REQ-039 Back-to-back: words 0x44332211 and 0x88776655 -> 8 beats in 8 consecutive cycles; IN_DEQ high in cycles 0 and 4.
REQ-040 Backpressure: OUT_RDY pattern 1,0,0,1,1,0,1 -> OUT_D stable across every stall; the sequence 11, 22, 33, 44 arrives with no loss and no duplication.
REQ-041 CLR after beats 11, 22 -> OUT_VALID=0 next cycle and IN_DEQ=0 in the CLR cycle; the next word 0xDDCCBBAA starts at AA.
REQ-042 Reset after 1 beat -> IDLE; no IN_DEQ during reset; the next word is emitted from lane 0.
